seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Consumer end of the stopwatch digit bus. Takes the four BCD digits produced by the MM:SS counter chain (S0, S1, M0, M1) and drives a 4-digit common-anode seven-segment display.
- Time-multiplexes the digits, decodes BCD to segments, and inserts a dead cycle between digits to prevent ghosting.
- Latches one coherent frame per scan so a carry ripple never tears the display.
- Sits between the timer and the board pins.

Parameters:
- SCAN_DIV, 50000: CLK cycles per digit slot; legal range is 2 or more.
- BLINK_DIV, 64: full scan frames per blink half-period; used only with the optional feature.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- D  input  16  BCD digits: D[3:0]=S0, D[7:4]=S1, D[11:8]=M0, D[15:12]=M1.
- EN  input  1  display enable; 0 forces all digits dark.
- LZB  input  1  leading-zero blank; 1 blanks the M1 digit when it is 0.
- COLON  input  1  1 lights DP on the M0 digit, forming the MM.SS separator.
- BLINK  input  1  blink request; only present with SEG7_BLINK_EN.
- AN  output  4  digit enables, active-low; AN[i] selects digit i (0=S0 … 3=M1).
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low.

Behaviour:
- Reset values (all outputs registered):
  - AN=4'b1111, SEG=7'b1111111, DP=1.
  - Prescaler cnt=0, digit index idx=3, frame register F=16'h0000, drive-pending flag P=0.
- Prescaler:
  - Each edge: if cnt==SCAN_DIV-1 then cnt<=0 and tick, else cnt<=cnt+1.
  - First tick occurs on the SCAN_DIV-th edge after RST deasserts.
- Tick edge (BLANK phase):
  - AN<=1111, SEG<=1111111, DP<=1.
  - idx<=idx+1 mod 4; P<=1.
  - If idx==3 (wrapping to 0), F<=D. D is sampled only here.
- Edge after tick (DRIVE phase), with P==1:
  - P<=0.
  - AN<=~(1<<idx) if EN=1, else 1111.
  - SEG<=decode(F digit idx), or 1111111 when EN=0 or the digit is blanked.
  - DP<=0 only when idx==2, COLON==1 and EN==1.
  - Outputs then hold until the next tick. Each slot is therefore 1 dark cycle plus SCAN_DIV-1 lit cycles.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10–15 show a dash, 0111111.
- Blanking: LZB=1 and F[15:12]==0 → during the idx=3 slot, AN stays 1111 and SEG stays 1111111.
- EN and COLON are sampled at the DRIVE edge. Changes mid-slot take effect at the next slot's DRIVE edge.
- D changing mid-frame has no visible effect until the next frame latch.
- RST mid-operation: all registers return to reset values on that edge, regardless of phase. No partial digit remains lit.
- Simultaneous tick and RST: RST wins.

Optional Feature:
- Macro SEG7_BLINK_EN.
- Defined:
  - BLINK port exists. A frame counter increments at each idx 3→0 wrap and toggles a phase bit every BLINK_DIV frames.
  - When BLINK=1 and the phase bit is 1, the DRIVE phase forces AN=1111 (all digits off). Otherwise display is normal.
  - Counter and phase reset to 0; the phase keeps running when BLINK=0.
- Undefined: no BLINK port, no frame counter. Behaviour is exactly as above.

Test Plan:
- Reset/first tick (SCAN_DIV=4), D=16'h1235, EN=1, LZB=0, COLON=0 → outputs stay at reset values for 4 edges. Edge 4 is BLANK (AN=1111). Edge 5: AN=1110, SEG=0010010 (digit 5).
- Full frame (same setup) → successive DRIVE edges give:
  - AN=1101, SEG=0110000 (3)
  - AN=1011, SEG=0100100 (2)
  - AN=0111, SEG=1111001 (1)
  - Each DRIVE edge is preceded by exactly one AN=1111 cycle.
- Frame coherence: change D to 16'h5959 during the idx=1 slot → remaining slots still show 3, 2, 1. The next frame shows 9, 5, 9, 5.
- Blanking/colon: D=16'h0407, LZB=1, COLON=1 → idx=2 slot shows SEG=0011001 with DP=0; idx=3 slot keeps AN=1111. Invalid digit D[3:0]=4'hC → SEG=0111111.
- EN and reset: EN=0 → AN=1111 from the next DRIVE edge. RST pulsed during a DRIVE slot → next edge gives AN=1111, SEG=1111111, DP=1, and the scan restarts at idx 0 after 4 edges.
- SEG7_BLINK_EN with BLINK_DIV=2, BLINK=1 → digits lit for 2 frames, dark (AN=1111) for 2 frames, repeating.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 4-digit common-anode seven-segment driver with a
// dead cycle between digits and a per-frame digit latch. Optional blink gating: SEG7_BLINK_EN.
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] D,
    input  logic        EN,
    input  logic        LZB,
    input  logic        COLON,
`ifdef SEG7_BLINK_EN
    input  logic        BLINK,
`endif
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    // state    | meaning
    // ST_HOLD  | outputs hold (reset, or lit part of a slot)
    // ST_DRIVE | dark cycle just issued; drive the new digit on the next edge
    typedef enum logic {ST_HOLD, ST_DRIVE} state_t;

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;
    logic          tick;
    logic [1:0]    idx;
    logic [15:0]   frame;
    state_t        state, state_nxt;
    logic [3:0]    nib;
    logic          blank;
    logic          blink_off;
    logic [3:0]    an_drv;
    logic [6:0]    seg_drv;
    logic          dp_drv;

    assign tick = (cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_HOLD;
        an_drv    = 4'b1111;
        seg_drv   = 7'b1111111;
        dp_drv    = 1'b1;
        nib       = frame[{idx, 2'b00} +: 4];
        blank     = LZB && (idx == 2'd3) && (nib == 4'd0);
        if (tick) begin
            state_nxt = ST_DRIVE;
        end
        if (EN && !blank) begin
            case (nib)
                4'd0:    seg_drv = 7'b1000000;
                4'd1:    seg_drv = 7'b1111001;
                4'd2:    seg_drv = 7'b0100100;
                4'd3:    seg_drv = 7'b0110000;
                4'd4:    seg_drv = 7'b0011001;
                4'd5:    seg_drv = 7'b0010010;
                4'd6:    seg_drv = 7'b0000010;
                4'd7:    seg_drv = 7'b1111000;
                4'd8:    seg_drv = 7'b0000000;
                4'd9:    seg_drv = 7'b0010000;
                default: seg_drv = 7'b0111111;
            endcase
            if (!blink_off) begin
                an_drv = ~(4'b0001 << idx);
            end
        end
        if (EN && COLON && (idx == 2'd2)) begin
            dp_drv = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= '0;
            idx   <= 2'd3;
            frame <= 16'h0000;
            AN    <= 4'b1111;
            SEG   <= 7'b1111111;
            DP    <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                AN  <= 4'b1111;
                SEG <= 7'b1111111;
                DP  <= 1'b1;
                idx <= idx + 2'd1;
                // D is captured once per frame so a carry ripple cannot tear the display
                if (idx == 2'd3) begin
                    frame <= D;
                end
            end else if (state == ST_DRIVE) begin
                AN  <= an_drv;
                SEG <= seg_drv;
                DP  <= dp_drv;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int FW = $clog2(BLINK_DIV + 1);

    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick && (idx == 2'd3)) begin
            if (frame_cnt == FW'(BLINK_DIV - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_off = BLINK && blink_phase;
`else
    logic unused_cfg;
    assign unused_cfg = ^32'(BLINK_DIV);
    assign blink_off  = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count reference model queues expected pins,
// a negedge monitor pops and compares them.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] D;
    logic        EN;
    logic        LZB;
    logic        COLON;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(2)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .D     (D),
        .EN    (EN),
        .LZB   (LZB),
        .COLON (COLON),
        .AN    (AN),
        .SEG   (SEG),
        .DP    (DP)
    );

    always #5 CLK = ~CLK;

    logic [6:0]  seg_tab [16];
    logic [11:0] exp_q [$];

    initial begin
        seg_tab[0]  = 7'b1000000;
        seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100;
        seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001;
        seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010;
        seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000;
        seg_tab[9]  = 7'b0010000;
        for (int k = 10; k < 16; k++) seg_tab[k] = 7'b0111111;
    end

    // Reference model: n counts edges since reset; every SCAN_DIV-th edge is a dark slot
    // boundary, the following edge lights the digit of that slot from the latched frame.
    int          n = 0;
    int          digit;
    logic [15:0] frame_m = 16'h0000;
    logic [3:0]  nib_m;
    logic        lit_m;
    logic [3:0]  exp_an  = 4'b1111;
    logic [6:0]  exp_seg = 7'b1111111;
    logic        exp_dp  = 1'b1;
    logic [3:0]  one4 = 4'b0001;

    always @(posedge CLK) begin
        if (RST) begin
            n       = 0;
            frame_m = 16'h0000;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
        end else begin
            n++;
            if (n % SCAN_DIV == 0) begin
                digit   = ((n / SCAN_DIV) - 1) % 4;
                exp_an  = 4'b1111;
                exp_seg = 7'b1111111;
                exp_dp  = 1'b1;
                if (digit == 0) frame_m = D;
            end else if (n > SCAN_DIV && n % SCAN_DIV == 1) begin
                digit   = ((n / SCAN_DIV) - 1) % 4;
                nib_m   = 4'((frame_m >> (4 * digit)) & 16'h000F);
                lit_m   = EN && !(LZB && digit == 3 && nib_m == 4'd0);
                exp_an  = lit_m ? ~(one4 << digit) : 4'b1111;
                exp_seg = lit_m ? seg_tab[nib_m] : 7'b1111111;
                exp_dp  = !(digit == 2 && COLON && EN);
            end
        end
        exp_q.push_back({exp_an, exp_seg, exp_dp});
    end

    logic [11:0] exp_v;

    always @(negedge CLK) begin
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL queue_empty at %0t: no expected value for DUT output AN=%b SEG=%b DP=%b",
                     $time, AN, SEG, DP);
        end else begin
            exp_v = exp_q.pop_front();
            if ({AN, SEG, DP} !== exp_v) begin
                errors++;
                $display("FAIL pins at %0t: actual AN=%b SEG=%b DP=%b required AN=%b SEG=%b DP=%b",
                         $time, AN, SEG, DP, exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
        end
    end

    task automatic run(input int cyc);
        repeat (cyc) @(negedge CLK);
    endtask

    function automatic logic [3:0] rand_nib();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        RST   = 1'b1;
        D     = 16'h1235;
        EN    = 1'b1;
        LZB   = 1'b0;
        COLON = 1'b0;
        run(2);
        RST = 1'b0;
        // edges 8..11 after release form the idx=1 slot of the first frame
        run(9);
        D = 16'h5959;
        run(40);
        D     = 16'h0407;
        LZB   = 1'b1;
        COLON = 1'b1;
        run(40);
        D = 16'h040C;
        run(20);
        EN = 1'b0;
        run(12);
        EN = 1'b1;
        run(6);
        RST = 1'b1;
        run(1);
        RST = 1'b0;
        run(30);
        for (int it = 0; it < 400; it++) begin
            run($urandom_range(1, 12));
            D     = {($urandom_range(0, 2) == 0) ? 4'd0 : rand_nib(), rand_nib(), rand_nib(), rand_nib()};
            EN    = ($urandom_range(0, 4) != 0);
            LZB   = 1'($urandom_range(0, 1));
            COLON = 1'($urandom_range(0, 1));
            RST   = ($urandom_range(0, 29) == 0);
        end
        RST = 1'b0;
        run(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
